midi_voice_alloc: RTL

Polyphonic MIDI front end for the synth datapath. It receives MIDI bytes over the SPI link using the `SPI_sclk`/`SPI_mosi` pins, parses Note On and Note Off messages for one channel, and assigns notes to `NUM_VOICES` voice slots. It drives per-voice note, velocity and gate buses into the oscillator bank, plus LED status.

---
 rtl/midi_voice_alloc.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: SPI-fed MIDI Note On/Off parser driving NUM_VOICES voice slots.
// Optional macro VOICE_STEAL_EN: an allocate with every voice gated steals the oldest voice.
module midi_voice_alloc #(
    parameter int NUM_VOICES   = 8,
    parameter int MIDI_CHANNEL = 0,
    parameter int OMNI         = 0,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    SPI_sclk,
    input  logic                    SPI_mosi,
    output logic [7*NUM_VOICES-1:0] voice_note,
    output logic [7*NUM_VOICES-1:0] voice_vel,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [7:0]              leds,
    output logic [7:0]              leds_2,
    output logic                    msg_err
);
    localparam int AW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [AW-1:0] AGE_MAX  = AW'(NUM_VOICES - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA1, DATA2} state_e;

    logic [2:0]    sclk_q, mosi_q;
    logic          rise_q;
    logic [6:0]    shift_q;
    logic [2:0]    bitcnt_q;
    logic [IW-1:0] idle_q;
    logic [7:0]    byte_q;
    logic          byte_valid_q;

    // Stage 0/1 synchronise the pins, stage 2 is the previous sample for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_q       <= '0;
            mosi_q       <= '0;
            rise_q       <= 1'b0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            idle_q       <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            sclk_q       <= {sclk_q[1:0], SPI_sclk};
            mosi_q       <= {mosi_q[1:0], SPI_mosi};
            rise_q       <= sclk_q[1] & ~sclk_q[2];
            byte_valid_q <= 1'b0;
            if (rise_q) begin
                idle_q   <= '0;
                shift_q  <= {shift_q[5:0], mosi_q[2]};
                bitcnt_q <= bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    byte_q       <= {shift_q, mosi_q[2]};
                    byte_valid_q <= 1'b1;
                end
            end else if (idle_q == IDLE_MAX) begin
                bitcnt_q <= '0;
            end else begin
                idle_q <= idle_q + IW'(1);
            end
        end
    end

    state_e     state_q, state_d;
    logic       rs_valid_q, rs_valid_d, rs_on_q, rs_on_d;
    logic [6:0] note_q, note_d;
    logic       ev_valid_q, ev_valid_d, ev_alloc_q, ev_alloc_d;
    logic [6:0] ev_note_q, ev_note_d, ev_vel_q, ev_vel_d;
    logic       err_q, err_d;
    logic       chan_ok;

    assign chan_ok = (OMNI != 0) || (byte_q[3:0] == 4'(MIDI_CHANNEL));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rs_valid_q <= 1'b0;
            rs_on_q    <= 1'b0;
            note_q     <= '0;
            ev_valid_q <= 1'b0;
            ev_alloc_q <= 1'b0;
            ev_note_q  <= '0;
            ev_vel_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_valid_q <= rs_valid_d;
            rs_on_q    <= rs_on_d;
            note_q     <= note_d;
            ev_valid_q <= ev_valid_d;
            ev_alloc_q <= ev_alloc_d;
            ev_note_q  <= ev_note_d;
            ev_vel_q   <= ev_vel_d;
            err_q      <= err_d;
        end
    end

    // Realtime bytes (0xF8..0xFF) fall through untouched.
    always_comb begin
        state_d    = state_q;
        rs_valid_d = rs_valid_q;
        rs_on_d    = rs_on_q;
        note_d     = note_q;
        ev_valid_d = 1'b0;
        ev_alloc_d = ev_alloc_q;
        ev_note_d  = ev_note_q;
        ev_vel_d   = ev_vel_q;
        err_d      = 1'b0;
        if (byte_valid_q && byte_q < 8'hF8) begin
            if (byte_q[7]) begin
                if ((byte_q[7:4] == 4'h8 || byte_q[7:4] == 4'h9) && chan_ok) begin
                    rs_valid_d = 1'b1;
                    rs_on_d    = byte_q[4];
                    state_d    = DATA1;
                end else begin
                    rs_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rs_valid_q) begin
                            note_d  = byte_q[6:0];
                            state_d = DATA2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    DATA1: begin
                        note_d  = byte_q[6:0];
                        state_d = DATA2;
                    end
                    DATA2: begin
                        ev_valid_d = 1'b1;
                        ev_alloc_d = rs_on_q && (byte_q[6:0] != 7'd0);
                        ev_note_d  = note_q;
                        ev_vel_d   = byte_q[6:0];
                        state_d    = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    logic [6:0]      vnote_q [NUM_VOICES];
    logic [6:0]      vvel_q  [NUM_VOICES];
    logic [AW-1:0]   age_q   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q;
    logic [6:0]      last_note_q;
    logic            hit, free, do_alloc;
    int              hit_idx, free_idx, old_idx, tgt_idx;
    logic [AW-1:0]   old_age;

    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = 0;
        free_idx = 0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_q[v] && vnote_q[v] == ev_note_q) begin
                hit     = 1'b1;
                hit_idx = v;
            end
            if (!gate_q[v]) begin
                free     = 1'b1;
                free_idx = v;
            end
        end
        old_idx = 0;
        old_age = age_q[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (age_q[v] > old_age) begin
                old_idx = v;
                old_age = age_q[v];
            end
        end
        do_alloc = 1'b0;
        tgt_idx  = 0;
        if (hit) begin
            do_alloc = 1'b1;
            tgt_idx  = hit_idx;
        end else if (free) begin
            do_alloc = 1'b1;
            tgt_idx  = free_idx;
        end
`ifdef VOICE_STEAL_EN
        else begin
            do_alloc = 1'b1;
            tgt_idx  = old_idx;
        end
`else
        else begin
            do_alloc = 1'b0;
            tgt_idx  = old_idx;
        end
`endif
    end

    // Release clears every matching voice but leaves note/velocity on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            gate_q      <= '0;
            last_note_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                vnote_q[v] <= '0;
                vvel_q[v]  <= '0;
                age_q[v]   <= '0;
            end
        end else if (ev_valid_q) begin
            last_note_q <= ev_note_q;
            if (ev_alloc_q) begin
                if (do_alloc) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (v == tgt_idx) begin
                            vnote_q[v] <= ev_note_q;
                            vvel_q[v]  <= ev_vel_q;
                            gate_q[v]  <= 1'b1;
                            age_q[v]   <= '0;
                        end else if (gate_q[v] && age_q[v] != AGE_MAX) begin
                            age_q[v] <= age_q[v] + AW'(1);
                        end
                    end
                end
            end else begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (vnote_q[v] == ev_note_q) gate_q[v] <= 1'b0;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
        assign voice_note[7*v +: 7] = vnote_q[v];
        assign voice_vel[7*v +: 7]  = vvel_q[v];
    end

    assign voice_gate = gate_q;
    assign leds       = 8'(gate_q);
    assign leds_2     = {1'b0, last_note_q};
    assign msg_err    = err_q;
endmodule
